alu_exec: RTL and testbench

Parametrised execute-stage ALU for the MIPS core. It merges the `aluop`/`funct` decode with datapath arithmetic and adds an iterative multiply/divide unit with architectural HI/LO registers. The unit stalls the pipeline through `busy` while a multi-cycle operation runs. It sits between the ID/EX pipeline register and the EX/MEM register, replacing the separate decode-plus-ALU pair.

---
 rtl/alu_exec.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_alu_exec.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with aluop/funct decode, HI/LO registers and an
// iterative multiply/divide sequencer that stalls the pipe through busy.
// Optional feature: define ALU_EXEC_DIV_EN to compile in the restoring divider
// and the div/divu decode; without it those funct codes decode as unlisted.
module alu_exec #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
`ifdef ALU_EXEC_DIV_EN
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

  localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W  = (2*WIDTH)'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(WIDTH-1);

`ifdef ALU_EXEC_DIV_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1} state_t;
`endif

  state_t             state_r, state_n_s;
  logic [WIDTH-1:0]   result_r, hi_r, lo_r;
  logic               zero_r, ovf_r, out_valid_r, busy_r, done_r;
  logic [CNT_W-1:0]   cnt_r;
  // opa_r holds the multiplicand (mul) or divisor (div); work_hi_r/work_lo_r
  // hold the running upper half/remainder and multiplier/quotient.
  logic [WIDTH-1:0]   opa_r, work_hi_r, work_lo_r;
  logic               neg_res_r;

  logic               accept_s, last_s;
  logic [WIDTH-1:0]   res_s, sum_s, diff_s, abs_a_s, abs_b_s;
  logic               ovf_s, start_mul_s, signed_op_s, wr_hi_s, wr_lo_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH-1:0]   mul_hi_n_s, mul_lo_n_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;

`ifdef ALU_EXEC_DIV_EN
  logic               neg_rem_r, divzero_r;
  logic [WIDTH-1:0]   a_orig_r;
  logic               start_div_s, div_ge_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH-1:0]   div_rem_n_s, div_q_n_s, quo_fix_s, rem_fix_s;
`endif

  assign accept_s = in_valid & ~busy_r;
  assign last_s   = (cnt_r == CNT_END);
  assign sum_s    = a + b;
  assign diff_s   = a - b;
  assign abs_a_s  = (signed_op_s && a[WIDTH-1]) ? (~a + ONE_W) : a;
  assign abs_b_s  = (signed_op_s && b[WIDTH-1]) ? (~b + ONE_W) : b;

  // Shift-add step: add the multiplicand when the multiplier LSB is set, then
  // shift the {carry, upper, multiplier} chain right by one.
  assign mul_sum_s  = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, opa_r} : {(WIDTH+1){1'b0}});
  assign mul_hi_n_s = mul_sum_s[WIDTH:1];
  assign mul_lo_n_s = {mul_sum_s[0], work_lo_r[WIDTH-1:1]};
  assign prod_s     = {mul_hi_n_s, mul_lo_n_s};
  assign prod_fix_s = neg_res_r ? (~prod_s + ONE_2W) : prod_s;

`ifdef ALU_EXEC_DIV_EN
  // Restoring step: bring in the next dividend bit and subtract when it fits.
  // The remainder stays below the divisor, so the difference fits in WIDTH bits.
  assign div_shift_s = {work_hi_r, work_lo_r[WIDTH-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, opa_r});
  assign div_rem_n_s = div_ge_s ? (div_shift_s[WIDTH-1:0] - opa_r) : div_shift_s[WIDTH-1:0];
  assign div_q_n_s   = {work_lo_r[WIDTH-2:0], div_ge_s};
  assign quo_fix_s   = divzero_r ? {WIDTH{1'b1}} : (neg_res_r ? (~div_q_n_s + ONE_W) : div_q_n_s);
  assign rem_fix_s   = divzero_r ? a_orig_r : (neg_rem_r ? (~div_rem_n_s + ONE_W) : div_rem_n_s);
`endif

  // Operation decode: single-cycle result/overflow and multi-cycle start requests.
  always_comb begin
    res_s       = {WIDTH{1'b0}};
    ovf_s       = 1'b0;
    start_mul_s = 1'b0;
    signed_op_s = 1'b0;
    wr_hi_s     = 1'b0;
    wr_lo_s     = 1'b0;
`ifdef ALU_EXEC_DIV_EN
    start_div_s = 1'b0;
`endif
    case (aluop)
      2'b00: res_s = sum_s;
      2'b01: res_s = diff_s;
      default: begin
        case (funct)
          F_ADD: begin
            res_s = sum_s;
            ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
          end
          F_SUB: begin
            res_s = diff_s;
            ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
          end
          F_ADDU:  res_s = sum_s;
          F_SUBU:  res_s = diff_s;
          F_AND:   res_s = a & b;
          F_OR:    res_s = a | b;
          F_XOR:   res_s = a ^ b;
          F_NOR:   res_s = ~(a | b);
          F_SLT:   res_s = ($signed(a) < $signed(b)) ? ONE_W : {WIDTH{1'b0}};
          F_SLTU:  res_s = (a < b) ? ONE_W : {WIDTH{1'b0}};
          F_MFHI:  res_s = hi_r;
          F_MFLO:  res_s = lo_r;
          F_MTHI: begin
            res_s   = a;
            wr_hi_s = 1'b1;
          end
          F_MTLO: begin
            res_s   = a;
            wr_lo_s = 1'b1;
          end
          F_MULT: begin
            start_mul_s = 1'b1;
            signed_op_s = 1'b1;
          end
          F_MULTU: start_mul_s = 1'b1;
`ifdef ALU_EXEC_DIV_EN
          F_DIV: begin
            start_div_s = 1'b1;
            signed_op_s = 1'b1;
          end
          F_DIVU: start_div_s = 1'b1;
`endif
          default: res_s = {WIDTH{1'b0}};
        endcase
      end
    endcase
  end

  // Sequencer next state: leave IDLE on a multi-cycle accept, return after WIDTH steps.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && start_mul_s) begin
          state_n_s = ST_MUL;
`ifdef ALU_EXEC_DIV_EN
        end else if (accept_s && start_div_s) begin
          state_n_s = ST_DIV;
`endif
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_MUL: state_n_s = last_s ? ST_IDLE : ST_MUL;
`ifdef ALU_EXEC_DIV_EN
      ST_DIV: state_n_s = last_s ? ST_IDLE : ST_DIV;
`endif
      default: state_n_s = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_n_s;
  end

  // Result/flag registers, HI/LO and the iterative multiply/divide datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b1;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      hi_r        <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      opa_r       <= {WIDTH{1'b0}};
      work_hi_r   <= {WIDTH{1'b0}};
      work_lo_r   <= {WIDTH{1'b0}};
      neg_res_r   <= 1'b0;
`ifdef ALU_EXEC_DIV_EN
      neg_rem_r   <= 1'b0;
      divzero_r   <= 1'b0;
      a_orig_r    <= {WIDTH{1'b0}};
`endif
    end else begin
      done_r      <= 1'b0;
      out_valid_r <= accept_s;
      if (accept_s) begin
        result_r <= res_s;
        zero_r   <= (res_s == {WIDTH{1'b0}});
        ovf_r    <= ovf_s;
        if (wr_hi_s) hi_r <= a;
        if (wr_lo_s) lo_r <= a;
        if (start_mul_s) begin
          busy_r    <= 1'b1;
          cnt_r     <= {CNT_W{1'b0}};
          opa_r     <= abs_a_s;
          work_hi_r <= {WIDTH{1'b0}};
          work_lo_r <= abs_b_s;
          neg_res_r <= signed_op_s && (a[WIDTH-1] ^ b[WIDTH-1]);
        end
`ifdef ALU_EXEC_DIV_EN
        if (start_div_s) begin
          busy_r    <= 1'b1;
          cnt_r     <= {CNT_W{1'b0}};
          opa_r     <= abs_b_s;
          work_hi_r <= {WIDTH{1'b0}};
          work_lo_r <= abs_a_s;
          neg_res_r <= signed_op_s && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_r <= signed_op_s && a[WIDTH-1];
          divzero_r <= (b == {WIDTH{1'b0}});
          a_orig_r  <= a;
        end
`endif
      end
      case (state_r)
        ST_MUL: begin
          work_hi_r <= mul_hi_n_s;
          work_lo_r <= mul_lo_n_s;
          cnt_r     <= cnt_r + CNT_ONE;
          if (last_s) begin
            hi_r   <= prod_fix_s[2*WIDTH-1:WIDTH];
            lo_r   <= prod_fix_s[WIDTH-1:0];
            done_r <= 1'b1;
            busy_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
          end
        end
`ifdef ALU_EXEC_DIV_EN
        ST_DIV: begin
          work_hi_r <= div_rem_n_s;
          work_lo_r <= div_q_n_s;
          cnt_r     <= cnt_r + CNT_ONE;
          if (last_s) begin
            hi_r   <= rem_fix_s;
            lo_r   <= quo_fix_s;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign result    = result_r;
  assign zero      = zero_r;
  assign ovf       = ovf_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign hi        = hi_r;
  assign lo        = lo_r;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec (WIDTH=32). Expected single-cycle
// results are queued when an operation is issued and checked when out_valid rises.
module tb_alu_exec;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid;
  logic [1:0]   aluop;
  logic [5:0]   funct;
  logic [W-1:0] a, b;
  logic [W-1:0] result, hi, lo;
  logic         zero, ovf, out_valid, busy, done;

  alu_exec #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .aluop(aluop), .funct(funct),
    .a(a), .b(b), .result(result), .zero(zero), .ovf(ovf),
    .out_valid(out_valid), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         o;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  // Scoreboard monitor: every out_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out_valid: got result=%h, required no output", result);
      end else begin
        e = sbq.pop_front();
        if ({result, zero, ovf} !== e) begin
          bad++;
          $display("FAIL scoreboard: got result=%h zero=%b ovf=%b, required result=%h zero=%b ovf=%b",
                   result, zero, ovf, e.r, e.z, e.o);
        end
      end
    end else if (sbq.size() != 0) begin
      total++;
      bad++;
      e = sbq.pop_front();
      $display("FAIL missing_out_valid: got out_valid=%b, required 1 with result=%h", out_valid, e.r);
    end
  end

  // Independent reference for single-cycle operations: returns {ovf, result}.
  function automatic logic [W:0] model(input logic [1:0] op, input logic [5:0] fn,
                                       input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] s, d;
    s = x + y;
    d = x - y;
    if (op == 2'b00) return {1'b0, s};
    if (op == 2'b01) return {1'b0, d};
    case (fn)
      6'b100000: return {(x[W-1] == y[W-1]) && (s[W-1] != x[W-1]), s};
      6'b100010: return {(x[W-1] != y[W-1]) && (d[W-1] != x[W-1]), d};
      6'b100001: return {1'b0, s};
      6'b100011: return {1'b0, d};
      6'b100100: return {1'b0, x & y};
      6'b100101: return {1'b0, x | y};
      6'b100110: return {1'b0, x ^ y};
      6'b100111: return {1'b0, ~(x | y)};
      6'b101010: return {1'b0, (($signed(x) < $signed(y)) ? 32'd1 : 32'd0)};
      6'b101011: return {1'b0, ((x < y) ? 32'd1 : 32'd0)};
      default:   return {(W+1){1'b0}};
    endcase
  endfunction

  task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic acc, input logic [W-1:0] er,
                       input logic eo);
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    aluop    = op;
    funct    = fn;
    a        = x;
    b        = y;
    if (acc) sbq.push_back({er, (er == 32'd0), eo});
  endtask

  task automatic idle();
    @(negedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; aluop = 2'b00; funct = 6'd0; a = 32'd1; b = 32'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({result, zero, ovf, out_valid, busy, done} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_flags: got result=%h zero=%b ovf=%b ov=%b busy=%b done=%b, required 0 1 0 0 0 0",
               result, zero, ovf, out_valid, busy, done);
    end
    total++;
    if ({hi, lo} !== 64'h0) begin
      bad++;
      $display("FAIL reset_hilo: got hi=%h lo=%h, required 0 0", hi, lo);
    end
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_add_ovf();
    drive(2'b10, 6'b100000, 32'h7FFFFFFF, 32'd1, 1'b1, 32'h80000000, 1'b1);
    drive(2'b10, 6'b100001, 32'h7FFFFFFF, 32'd1, 1'b1, 32'h80000000, 1'b0);
    drive(2'b10, 6'b100010, 32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 1'b1);
    drive(2'b00, 6'b000000, 32'h7FFFFFFF, 32'd1, 1'b1, 32'h80000000, 1'b0);
    idle();
  endtask

  task automatic test_sub_zero();
    drive(2'b01, 6'b100000, 32'd5, 32'd5, 1'b1, 32'd0, 1'b0);
    idle();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL no_accept_out_valid: got %b, required 0", out_valid);
    end
  endtask

  task automatic test_single_random();
    logic [5:0]   fl [12];
    logic [1:0]   op;
    logic [5:0]   fn;
    logic [W-1:0] x, y;
    logic [W:0]   m;
    fl = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
           6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b111111};
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      fn = fl[$urandom_range(0, 11)];
      x  = (i % 4 == 0) ? 32'h80000000 : $urandom();
      y  = (i % 5 == 0) ? x : $urandom();
      m  = model(op, fn, x, y);
      drive(op, fn, x, y, 1'b1, m[W-1:0], m[W]);
    end
    idle();
  endtask

  task automatic test_mthi_mflo();
    drive(2'b10, 6'b010011, 32'h1234, 32'd0, 1'b1, 32'h1234, 1'b0);
    drive(2'b10, 6'b010010, 32'd0, 32'd0, 1'b1, 32'h1234, 1'b0);
    drive(2'b10, 6'b010001, 32'hABCD, 32'd0, 1'b1, 32'hABCD, 1'b0);
    drive(2'b10, 6'b010000, 32'd0, 32'd0, 1'b1, 32'hABCD, 1'b0);
    drive(2'b10, 6'b101011, 32'd1, 32'hFFFFFFFF, 1'b1, 32'd1, 1'b0);
    drive(2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b0);
    idle();
    @(negedge clk);
    total++;
    if ({hi, lo} !== {32'hABCD, 32'h1234}) begin
      bad++;
      $display("FAIL mt_hilo: got hi=%h lo=%h, required 0000abcd 00001234", hi, lo);
    end
  endtask

  task automatic test_mult();
    drive(2'b10, 6'b011000, 32'hFFFFFFFD, 32'd7, 1'b1, 32'd0, 1'b0);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL mult_busy_%0d: got busy=%b done=%b, required 1 0", k, busy, done);
      end
      #1;
      if (k == 5) begin
        in_valid = 1'b1; aluop = 2'b10; funct = 6'b010001; a = 32'h5555;
      end else if (k == 6) begin
        in_valid = 1'b1; aluop = 2'b10; funct = 6'b011001; a = 32'd2; b = 32'd3;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL mult_done: got busy=%b done=%b, required 0 1", busy, done);
    end
    total++;
    if ({hi, lo} !== {32'hFFFFFFFF, 32'hFFFFFFEB}) begin
      bad++;
      $display("FAIL mult_hilo: got hi=%h lo=%h, required ffffffff ffffffeb", hi, lo);
    end
    #1;
    in_valid = 1'b1; aluop = 2'b10; funct = 6'b010000;
    sbq.push_back({32'hFFFFFFFF, 1'b0, 1'b0});
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: got done=%b busy=%b, required 0 0", done, busy);
    end
    #1;
    in_valid = 1'b0;
  endtask

`ifdef ALU_EXEC_DIV_EN
  task automatic test_div();
    logic [W-1:0] ca [3];
    logic [W-1:0] cb [3];
    logic [5:0]   cf [3];
    logic [W-1:0] eh [3];
    logic [W-1:0] el [3];
    ca = '{32'hFFFFFFF9, 32'h12345678, 32'd100};
    cb = '{32'd2,        32'd0,        32'd7};
    cf = '{6'b011010,    6'b011011,    6'b011011};
    eh = '{32'hFFFFFFFF, 32'h12345678, 32'd2};
    el = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14};
    for (int c = 0; c < 3; c++) begin
      drive(2'b10, cf[c], ca[c], cb[c], 1'b1, 32'd0, 1'b0);
      for (int k = 1; k <= W; k++) begin
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          bad++;
          $display("FAIL div%0d_busy_%0d: got busy=%b done=%b, required 1 0", c, k, busy, done);
        end
        #1;
        in_valid = 1'b0;
      end
      @(negedge clk);
      total++;
      if (done !== 1'b1 || {hi, lo} !== {eh[c], el[c]}) begin
        bad++;
        $display("FAIL div%0d_result: got done=%b hi=%h lo=%h, required 1 %h %h",
                 c, done, hi, lo, eh[c], el[c]);
      end
    end
  endtask
`else
  task automatic test_div_disabled();
    drive(2'b10, 6'b011010, 32'hFFFFFFF9, 32'd2, 1'b1, 32'd0, 1'b0);
    idle();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL div_off_busy: got %b, required 0", busy);
    end
    @(negedge clk);
    total++;
    if ({hi, lo, done} !== {32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0}) begin
      bad++;
      $display("FAIL div_off_hilo: got hi=%h lo=%h done=%b, required ffffffff ffffffeb 0", hi, lo, done);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic seen_done;
    drive(2'b10, 6'b011001, 32'd3, 32'd5, 1'b1, 32'd0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      #1;
      in_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, out_valid, zero, hi, lo, result} !== {1'b0, 1'b0, 1'b0, 1'b1, 96'h0}) begin
      bad++;
      $display("FAIL mid_reset: got busy=%b done=%b ov=%b zero=%b hi=%h lo=%h result=%h, required 0 0 0 1 0 0 0",
               busy, done, out_valid, zero, hi, lo, result);
    end
    #1;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done: got done/busy activity=%b, required 0", seen_done);
    end
    drive(2'b10, 6'b100001, 32'd2, 32'd3, 1'b1, 32'd5, 1'b0);
    idle();
  endtask

  // Watchdog so a stuck run still terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_add_ovf();
    test_sub_zero();
    test_single_random();
    test_mthi_mflo();
    test_mult();
`ifdef ALU_EXEC_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_reset_mid();
    repeat (3) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL leftover_expect: got %0d pending, required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
